// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------------------------
// axi_rd_arbiter
//
// Purpose:
//   Shares one AXI read channel (AR/R) between three requesters: icache line refill, dcache
//   line refill and uncached dcache single-word read. Only one transaction is in flight at a
//   time. A read whose line matches an unfinished write is held back until the write clears.
//
// Ports:
//   aclk_i, aresetn_i          clock, asynchronous active-low reset
//   ic_rd_* / dc_rd_*          refill request, address, accept (rdy); line returned on
//   ic_ret_* / dc_ret_*        *_ret_data_o with a one-cycle *_ret_valid_o pulse
//   uc_rd_* / uc_ret_*         uncached single-word request and return
//   wr_busy_i, wr_busy_addr_i  pending write and its address (line granularity)
//   ar*_o, arready_i           AXI read address channel
//   rid_i .. rvalid_i, rready_o AXI read data channel
// ---------------------------------------------------------------------------------------------
module axi_rd_arbiter #(
    parameter int unsigned LINE_WORDS = 4,
    parameter logic [3:0]  ID_IC      = 4'd0,
    parameter logic [3:0]  ID_DC      = 4'd1,
    parameter logic [3:0]  ID_UC      = 4'd2
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,

    input  logic                      ic_rd_req_i,
    input  logic [31:0]               ic_rd_addr_i,
    output logic                      ic_rd_rdy_o,
    output logic                      ic_ret_valid_o,
    output logic [32*LINE_WORDS-1:0]  ic_ret_data_o,

    input  logic                      dc_rd_req_i,
    input  logic [31:0]               dc_rd_addr_i,
    output logic                      dc_rd_rdy_o,
    output logic                      dc_ret_valid_o,
    output logic [32*LINE_WORDS-1:0]  dc_ret_data_o,

    input  logic                      uc_rd_req_i,
    input  logic [31:0]               uc_rd_addr_i,
    output logic                      uc_rd_rdy_o,
    output logic                      uc_ret_valid_o,
    output logic [31:0]               uc_ret_data_o,

    input  logic                      wr_busy_i,
    input  logic [31:0]               wr_busy_addr_i,

    output logic [3:0]                arid_o,
    output logic [31:0]               araddr_o,
    output logic [3:0]                arlen_o,
    output logic [2:0]                arsize_o,
    output logic [1:0]                arburst_o,
    output logic [1:0]                arlock_o,
    output logic [3:0]                arcache_o,
    output logic [2:0]                arprot_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,

    input  logic [3:0]                rid_i,
    input  logic [31:0]               rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    input  logic                      rvalid_i,
    output logic                      rready_o
);

    localparam int unsigned  CntW      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(LINE_WORDS - 1);
    localparam logic [3:0]   RefillLen = 4'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StRet
    } state_e;

    typedef enum logic [1:0] {
        SelIc,
        SelDc,
        SelUc
    } sel_e;

    state_e                          state_q, state_d;
    sel_e                            sel_q, sel_d;
    logic [31:0]                     addr_q, addr_d;
    logic [3:0]                      id_q, id_d;
    logic [3:0]                      len_q, len_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [LINE_WORDS-1:0][31:0]     buf_q, buf_d;

    logic ic_blk, dc_blk, uc_blk;
    logic gnt_ic, gnt_dc, gnt_uc;
    logic beat_ok;

    // Response code and sub-line address bits play no part in arbitration.
    logic unused_bits;
    assign unused_bits = ^{rresp_i, ic_rd_addr_i[3:0], dc_rd_addr_i[3:0], wr_busy_addr_i[3:0]};

    // A read to the line an unfinished write targets must wait for that write.
    assign ic_blk = wr_busy_i && (ic_rd_addr_i[31:4] == wr_busy_addr_i[31:4]);
    assign dc_blk = wr_busy_i && (dc_rd_addr_i[31:4] == wr_busy_addr_i[31:4]);
    assign uc_blk = wr_busy_i && (uc_rd_addr_i[31:4] == wr_busy_addr_i[31:4]);

    // Fixed priority dc > uc > ic; rdy is suppressed while reset is asserted.
    always_comb begin
        gnt_ic = 1'b0;
        gnt_dc = 1'b0;
        gnt_uc = 1'b0;
        if (state_q == StIdle && aresetn_i) begin
            if (dc_rd_req_i && !dc_blk) begin
                gnt_dc = 1'b1;
            end else if (uc_rd_req_i && !uc_blk) begin
                gnt_uc = 1'b1;
            end else if (ic_rd_req_i && !ic_blk) begin
                gnt_ic = 1'b1;
            end
        end
    end

    assign ic_rd_rdy_o = gnt_ic;
    assign dc_rd_rdy_o = gnt_dc;
    assign uc_rd_rdy_o = gnt_uc;

    // Beats carrying another transaction's id are not ours and are dropped.
    assign beat_ok = rvalid_i && (rid_i == id_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_dc) begin
                    sel_d   = SelDc;
                    addr_d  = {dc_rd_addr_i[31:4], 4'h0};
                    id_d    = ID_DC;
                    len_d   = RefillLen;
                    cnt_d   = '0;
                    state_d = StAr;
                end else if (gnt_uc) begin
                    sel_d   = SelUc;
                    addr_d  = uc_rd_addr_i;
                    id_d    = ID_UC;
                    len_d   = 4'd0;
                    cnt_d   = '0;
                    state_d = StAr;
                end else if (gnt_ic) begin
                    sel_d   = SelIc;
                    addr_d  = {ic_rd_addr_i[31:4], 4'h0};
                    id_d    = ID_IC;
                    len_d   = RefillLen;
                    cnt_d   = '0;
                    state_d = StAr;
                end
            end
            StAr: begin
                if (arready_i) begin
                    state_d = StR;
                end
            end
            StR: begin
                if (beat_ok) begin
                    buf_d[cnt_q] = rdata_i;
                    // Saturate so surplus beats land in the last slot.
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (rlast_i) begin
                        state_d = StRet;
                    end
                end
            end
            StRet: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= StIdle;
            sel_q   <= SelIc;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // AR fields come straight from registers, so they are stable while arvalid is high.
    assign arvalid_o = (state_q == StAr);
    assign araddr_o  = addr_q;
    assign arid_o    = id_q;
    assign arlen_o   = len_q;
    assign arsize_o  = arvalid_o ? 3'b010 : 3'b000;
    assign arburst_o = arvalid_o ? 2'b01 : 2'b00;
    assign arlock_o  = 2'b00;
    assign arcache_o = 4'b0000;
    assign arprot_o  = 3'b000;
    assign rready_o  = (state_q == StR);

    assign ic_ret_valid_o = (state_q == StRet) && (sel_q == SelIc);
    assign dc_ret_valid_o = (state_q == StRet) && (sel_q == SelDc);
    assign uc_ret_valid_o = (state_q == StRet) && (sel_q == SelUc);

    // The line buffer is only written in StR, so return data holds until the next accept.
    assign ic_ret_data_o = buf_q;
    assign dc_ret_data_o = buf_q;
    assign uc_ret_data_o = buf_q[0];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Scoreboard bench: each issued request pushes its expected AR fields and returned data; an
// AXI slave model answers AR/R and checks the AR fields; a monitor pops and compares returns.
// ---------------------------------------------------------------------------------------------
module tb_axi_rd_arbiter;

    localparam int IC = 0;
    localparam int DC = 1;
    localparam int UC = 2;

    logic         aclk;
    logic         aresetn;
    logic         ic_rd_req, dc_rd_req, uc_rd_req;
    logic [31:0]  ic_rd_addr, dc_rd_addr, uc_rd_addr;
    logic         ic_rd_rdy, dc_rd_rdy, uc_rd_rdy;
    logic         ic_ret_valid, dc_ret_valid, uc_ret_valid;
    logic [127:0] ic_ret_data, dc_ret_data;
    logic [31:0]  uc_ret_data;
    logic         wr_busy;
    logic [31:0]  wr_busy_addr;
    logic [3:0]   arid, arlen, arcache;
    logic [31:0]  araddr;
    logic [2:0]   arsize, arprot;
    logic [1:0]   arburst, arlock;
    logic         arvalid, arready;
    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    axi_rd_arbiter #(
        .LINE_WORDS (4),
        .ID_IC      (4'd0),
        .ID_DC      (4'd1),
        .ID_UC      (4'd2)
    ) u_dut (
        .aclk_i         (aclk),
        .aresetn_i      (aresetn),
        .ic_rd_req_i    (ic_rd_req),
        .ic_rd_addr_i   (ic_rd_addr),
        .ic_rd_rdy_o    (ic_rd_rdy),
        .ic_ret_valid_o (ic_ret_valid),
        .ic_ret_data_o  (ic_ret_data),
        .dc_rd_req_i    (dc_rd_req),
        .dc_rd_addr_i   (dc_rd_addr),
        .dc_rd_rdy_o    (dc_rd_rdy),
        .dc_ret_valid_o (dc_ret_valid),
        .dc_ret_data_o  (dc_ret_data),
        .uc_rd_req_i    (uc_rd_req),
        .uc_rd_addr_i   (uc_rd_addr),
        .uc_rd_rdy_o    (uc_rd_rdy),
        .uc_ret_valid_o (uc_ret_valid),
        .uc_ret_data_o  (uc_ret_data),
        .wr_busy_i      (wr_busy),
        .wr_busy_addr_i (wr_busy_addr),
        .arid_o         (arid),
        .araddr_o       (araddr),
        .arlen_o        (arlen),
        .arsize_o       (arsize),
        .arburst_o      (arburst),
        .arlock_o       (arlock),
        .arcache_o      (arcache),
        .arprot_o       (arprot),
        .arvalid_o      (arvalid),
        .arready_i      (arready),
        .rid_i          (rid),
        .rdata_i        (rdata),
        .rresp_i        (rresp),
        .rlast_i        (rlast),
        .rvalid_i       (rvalid),
        .rready_o       (rready)
    );

    typedef struct {
        int           who;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [3:0]   id;
        logic [127:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          issue_cnt [3];
    int          done_cnt  [3];
    int          acc_cyc   [3];
    logic [31:0] want_addr [3];
    logic [2:0]  req_v;
    logic [2:0]  rdy_v;

    // Slave behaviour knobs.
    int   ar_stall = 0;
    logic gap_en   = 1'b0;
    logic intl_en  = 1'b0;
    logic r_hold   = 1'b0;
    logic fast     = 1'b1;

    assign ic_rd_req = req_v[0];
    assign dc_rd_req = req_v[1];
    assign uc_rd_req = req_v[2];
    assign rdy_v     = {uc_rd_rdy, dc_rd_rdy, ic_rd_rdy};

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a, input int i);
        logic [31:0] k;
        k = 32'(i + 1);
        return a ^ (32'h0101_0101 * k) ^ 32'h5a00_0000;
    endfunction

    function automatic exp_t mk_exp(input int k, input logic [31:0] a);
        exp_t e;
        e.who  = k;
        e.addr = (k == UC) ? a : {a[31:4], 4'h0};
        e.len  = (k == UC) ? 4'd0 : 4'd3;
        e.id   = (k == IC) ? 4'd0 : ((k == DC) ? 4'd1 : 4'd2);
        e.data = '0;
        if (k == UC) begin
            e.data[31:0] = rd_word(e.addr, 0);
        end else begin
            for (int i = 0; i < 4; i++) e.data[32*i +: 32] = rd_word(e.addr, i);
        end
        return e;
    endfunction

    task automatic issue(input int k, input logic [31:0] a);
        sb.push_back(mk_exp(k, a));
        want_addr[k] = a;
        issue_cnt[k]++;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check(tag, sb.size(), 0);
        repeat (2) @(negedge aclk);
    endtask

    // Requester driver: raise req for every outstanding issue, drop it after acceptance.
    always begin
        @(posedge aclk);
        #1;
        for (int k = 0; k < 3; k++) req_v[k] = (issue_cnt[k] != done_cnt[k]);
        ic_rd_addr = want_addr[IC];
        dc_rd_addr = want_addr[DC];
        uc_rd_addr = want_addr[UC];
    end

    // Monitor: acceptance bookkeeping and return checking against the scoreboard.
    always @(negedge aclk) begin
        logic [2:0]   rets;
        logic [127:0] obs;
        int           who;
        exp_t         e;
        for (int k = 0; k < 3; k++) begin
            if (req_v[k] && rdy_v[k]) begin
                done_cnt[k]++;
                acc_cyc[k] = cyc;
            end
        end
        if (rdy_v != 3'b000) check("rdy_onehot", $countones(rdy_v), 1);
        rets = {uc_ret_valid, dc_ret_valid, ic_ret_valid};
        if (rets != 3'b000) begin
            check("ret_onehot", $countones(rets), 1);
            who = rets[0] ? IC : (rets[1] ? DC : UC);
            obs = (who == IC) ? ic_ret_data : ((who == DC) ? dc_ret_data : {96'h0, uc_ret_data});
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("ret_who", who, e.who);
                check("ret_data", obs, e.data);
                if (fast) check("ret_latency", cyc - acc_cyc[who], (e.len == 0) ? 3 : 6);
            end
        end
    end

    // AXI slave model: data words derive from the address seen on AR.
    initial begin
        logic [31:0] a_addr;
        logic [3:0]  a_len, a_id;
        int          nb;
        arready = 1'b0;
        rvalid  = 1'b0;
        rid     = '0;
        rdata   = '0;
        rresp   = '0;
        rlast   = 1'b0;
        forever begin
            @(negedge aclk);
            if (arvalid && aresetn) begin
                a_addr = araddr;
                a_len  = arlen;
                a_id   = arid;
                if (sb.size() != 0) begin
                    check("ar_addr", araddr, sb[0].addr);
                    check("ar_len", arlen, sb[0].len);
                    check("ar_id", arid, sb[0].id);
                end else begin
                    check("ar_unexpected", sb.size(), 1);
                end
                check("ar_size", arsize, 3'b010);
                check("ar_burst", arburst, 2'b01);
                check("ar_misc", {arlock, arcache, arprot}, 9'h0);
                for (int s = 0; s < ar_stall; s++) begin
                    check("ar_hold_valid", arvalid, 1'b1);
                    check("ar_hold_addr", araddr, a_addr);
                    check("ar_hold_len", arlen, a_len);
                    check("rready_before_ar", rready, 1'b0);
                    @(negedge aclk);
                end
                arready = 1'b1;
                @(negedge aclk);
                arready = 1'b0;
                nb = int'(a_len) + 1;
                for (int b = 0; b < nb; b++) begin
                    while (r_hold && aresetn) @(negedge aclk);
                    if (!aresetn) break;
                    if (gap_en && b == 1) repeat (2) @(negedge aclk);
                    if (intl_en && b == 2) begin
                        rvalid = 1'b1;
                        rid    = 4'd3;
                        rdata  = 32'hdead_beef;
                        rlast  = 1'b1;
                        @(negedge aclk);
                    end
                    rvalid = 1'b1;
                    rid    = a_id;
                    rdata  = rd_word(a_addr, b);
                    rlast  = (b == nb - 1);
                    rresp  = gap_en ? 2'b10 : 2'b00;
                    check("rready_in_r", rready, 1'b1);
                    @(negedge aclk);
                    rvalid = 1'b0;
                    rlast  = 1'b0;
                end
                rvalid = 1'b0;
                rlast  = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            issue_cnt[k] = 0;
            done_cnt[k]  = 0;
            acc_cyc[k]   = 0;
            want_addr[k] = '0;
        end
        req_v        = '0;
        ic_rd_addr   = '0;
        dc_rd_addr   = '0;
        uc_rd_addr   = '0;
        wr_busy      = 1'b0;
        wr_busy_addr = '0;
        aresetn      = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_ar_fields", {araddr, arid, arlen}, 40'h0);
        check("rst_rdy", rdy_v, 3'b000);
        check("rst_ret_valid", {ic_ret_valid, dc_ret_valid, uc_ret_valid}, 3'b000);
        check("rst_ret_data", dc_ret_data, 128'h0);
        aresetn = 1'b1;
        @(negedge aclk);

        // 1: single dcache refill, everything ready.
        fast = 1'b1;
        issue(DC, 32'h1fc0_0010);
        @(posedge aclk);
        #2;
        check("t1_dc_rdy", dc_rd_rdy, 1'b1);
        wait_drain("t1_drain", 40);

        // 2: three simultaneous requests, served dc, uc, ic.
        issue(DC, 32'h0000_3010);
        issue(UC, 32'h1fd0_0004);
        issue(IC, 32'h0000_4008);
        wait_drain("t2_drain", 80);

        // 3: dc blocked by pending write to its line, ic proceeds.
        @(posedge aclk);
        #1;
        wr_busy      = 1'b1;
        wr_busy_addr = 32'h0000_1234;
        issue(IC, 32'h0000_2000);
        issue(DC, 32'h0000_1230);
        n = 0;
        while (sb.size() != 1 && n < 40) begin
            @(negedge aclk);
            n++;
        end
        check("t3_ic_first", sb.size(), 1);
        repeat (3) begin
            @(negedge aclk);
            check("t3_dc_blocked", dc_rd_rdy, 1'b0);
        end
        @(posedge aclk);
        #1;
        wr_busy = 1'b0;
        #1;
        check("t3_dc_rdy", dc_rd_rdy, 1'b1);
        wait_drain("t3_drain", 40);

        // 4: arready withheld for five cycles.
        fast     = 1'b0;
        ar_stall = 5;
        issue(DC, 32'h0000_5554);
        wait_drain("t4_drain", 60);
        ar_stall = 0;

        // 5: foreign-id beat and rvalid gaps inside a refill.
        gap_en  = 1'b1;
        intl_en = 1'b1;
        issue(DC, 32'h0000_6660);
        wait_drain("t5_drain", 60);
        issue(IC, 32'h0000_7700);
        wait_drain("t5_ic_drain", 60);
        gap_en  = 1'b0;
        intl_en = 1'b0;

        // 6: reset in the middle of the R phase.
        r_hold = 1'b1;
        issue(DC, 32'h0000_7770);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!rready && n < 20);
        check("t6_in_r", rready, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_rst_arvalid", arvalid, 1'b0);
        check("t6_rst_rready", rready, 1'b0);
        check("t6_rst_rdy", rdy_v, 3'b000);
        check("t6_rst_ret", {ic_ret_valid, dc_ret_valid, uc_ret_valid}, 3'b000);
        check("t6_rst_ar", {araddr, arid, arlen}, 40'h0);
        check("t6_rst_data", {dc_ret_data, uc_ret_data}, 160'h0);
        sb.delete();
        repeat (2) @(negedge aclk);
        r_hold  = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        check("t6_idle_arvalid", arvalid, 1'b0);
        check("t6_idle_rready", rready, 1'b0);
        fast = 1'b1;
        issue(UC, 32'h1fd0_0008);
        wait_drain("t6_uc_drain", 40);
        issue(IC, 32'h0000_8880);
        wait_drain("t6_ic_drain", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
